// File: rtl/mem_access.sv
// mem_access: cqu_mips memory-access stage.
// EX/MEM register, dmem req/ready FSM, load align/extend, MEM/WB register.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        valid_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  write_reg_in,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [1:0]  mem_size_in,
   input  logic        mem_unsigned_in,
   input  logic [31:0] inst_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] final_result,
   output logic [4:0]  write_reg,
   output logic        reg_write_final,
   output logic        mem_to_reg_final,
   output logic [31:0] inst_out,
   output logic        mem_stall,
   output logic        addr_err,
   output logic [31:0] bad_vaddr
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t state_q, state_d;

   logic        valid_q, rw_q, m2r_q, mr_q, mw_q, uns_q;
   logic [31:0] alu_q, sd_q, inst_q, buf_q;
   logic [4:0]  wreg_q;
   logic [1:0]  size_q;

   logic [31:0] res_q, iout_q, bad_q;
   logic [4:0]  wr_q;
   logic        rwf_q, m2rf_q, aerr_q;

   logic        vin, in_mem, capture, hold_exit, mis_q;
   logic [31:0] ld_data;

   function automatic logic misal(input logic [1:0] sz, input logic [1:0] a);
      return (sz[1] && a != 2'b00) || (sz == 2'b01 && a[0]);
   endfunction

   function automatic logic [31:0] ld_ext(input logic [31:0] d,
                                          input logic [1:0]  sz,
                                          input logic        u,
                                          input logic [1:0]  a);
      logic [31:0] sb, sh;
      sb = d >> {a, 3'b000};
      sh = d >> {a[1], 4'b0000};
      unique case (sz)
         2'b00:   return u ? {24'd0, sb[7:0]} : {{24{sb[7]}}, sb[7:0]};
         2'b01:   return u ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return d;
      endcase
   endfunction

   assign vin       = valid_in && !flush;
   assign in_mem    = vin && (mem_read_in || mem_write_in)
                      && !misal(mem_size_in, alu_result_in[1:0]);
   assign capture   = !stall && !mem_stall && state_q != HOLD;
   assign hold_exit = state_q == HOLD && !stall;
   assign mis_q     = valid_q && (mr_q || mw_q) && misal(size_q, alu_q[1:0]);
   assign ld_data   = ld_ext(state_q == HOLD ? buf_q : dmem_rdata,
                             size_q, uns_q, alu_q[1:0]);

   // EX/MEM pipeline register; a retired HOLD op leaves a bubble behind
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         alu_q   <= '0;
         sd_q    <= '0;
         wreg_q  <= '0;
         rw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         inst_q  <= '0;
      end else if (capture) begin
         valid_q <= vin;
         alu_q   <= alu_result_in;
         sd_q    <= store_data_in;
         wreg_q  <= write_reg_in;
         rw_q    <= vin && reg_write_in;
         m2r_q   <= vin && mem_to_reg_in;
         mr_q    <= vin && mem_read_in;
         mw_q    <= vin && mem_write_in;
         size_q  <= mem_size_in;
         uns_q   <= mem_unsigned_in;
         inst_q  <= inst_in;
      end else if (hold_exit) begin
         valid_q <= 1'b0;
      end
   end

   // FSM state register and read-data buffer for stall-on-ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == REQ && dmem_ready && stall)
            buf_q <= dmem_rdata;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (!stall && in_mem) state_d = REQ;
         REQ: begin
            if (dmem_ready) begin
               if (stall) state_d = HOLD;
               else       state_d = in_mem ? REQ : IDLE;
            end
         end
         HOLD:    if (!stall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: memory request lines and stage stall
   always_comb begin
      dmem_req   = state_q == REQ;
      dmem_we    = dmem_req && mw_q;
      dmem_addr  = {alu_q[31:2], 2'b00};
      mem_stall  = dmem_req && !dmem_ready;
      dmem_wstrb = 4'b0000;
      dmem_wdata = '0;
      if (dmem_we) begin
         unique case (size_q)
            2'b00: begin
               dmem_wstrb = 4'b0001 << alu_q[1:0];
               dmem_wdata = {4{sd_q[7:0]}};
            end
            2'b01: begin
               dmem_wstrb = alu_q[1] ? 4'b1100 : 4'b0011;
               dmem_wdata = {2{sd_q[15:0]}};
            end
            default: begin
               dmem_wstrb = 4'b1111;
               dmem_wdata = sd_q;
            end
         endcase
      end
   end

   // MEM/WB register; addr_err is a single-edge pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q  <= '0;
         wr_q   <= '0;
         rwf_q  <= 1'b0;
         m2rf_q <= 1'b0;
         iout_q <= '0;
         aerr_q <= 1'b0;
         bad_q  <= '0;
      end else begin
         aerr_q <= 1'b0;
         if (!stall) begin
            unique case (state_q)
               IDLE: begin
                  if (!valid_q) begin
                     rwf_q <= 1'b0;
                  end else begin
                     wr_q   <= wreg_q;
                     m2rf_q <= m2r_q;
                     iout_q <= inst_q;
                     if (mis_q) begin
                        res_q  <= '0;
                        rwf_q  <= 1'b0;
                        aerr_q <= 1'b1;
                        bad_q  <= alu_q;
                     end else begin
                        res_q <= alu_q;
                        rwf_q <= rw_q;
                     end
                  end
               end
               REQ, HOLD: begin
                  if (state_q == REQ && !dmem_ready) begin
                     rwf_q <= 1'b0;
                  end else begin
                     wr_q   <= wreg_q;
                     m2rf_q <= m2r_q;
                     iout_q <= inst_q;
                     res_q  <= mw_q ? 32'd0 : ld_data;
                     rwf_q  <= rw_q && !mw_q;
                  end
               end
               default: rwf_q <= 1'b0;
            endcase
         end
      end
   end

   assign final_result     = res_q;
   assign write_reg        = wr_q;
   assign reg_write_final  = rwf_q;
   assign mem_to_reg_final = m2rf_q;
   assign inst_out         = iout_q;
   assign addr_err         = aerr_q;
   assign bad_vaddr        = bad_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors for the mem_access stage.
// Hand-computed expectations, one check task, one summary line.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst, stall, flush, valid_in;
   logic [31:0] alu_result_in, store_data_in, inst_in;
   logic [4:0]  write_reg_in;
   logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
   logic [1:0]  mem_size_in;
   logic        mem_unsigned_in;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] final_result, inst_out, bad_vaddr;
   logic [4:0]  write_reg;
   logic        reg_write_final, mem_to_reg_final, mem_stall, addr_err;

   int checks = 0;
   int failures = 0;
   int stalls;

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .valid_in(valid_in), .alu_result_in(alu_result_in),
      .store_data_in(store_data_in), .write_reg_in(write_reg_in),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
      .inst_in(inst_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .final_result(final_result),
      .write_reg(write_reg), .reg_write_final(reg_write_final),
      .mem_to_reg_final(mem_to_reg_final), .inst_out(inst_out),
      .mem_stall(mem_stall), .addr_err(addr_err), .bad_vaddr(bad_vaddr)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] wr,
                        input logic rw, input logic m2r,
                        input logic mr, input logic mw,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] inst);
      valid_in        = v;
      alu_result_in   = alu;
      store_data_in   = sd;
      write_reg_in    = wr;
      reg_write_in    = rw;
      mem_to_reg_in   = m2r;
      mem_read_in     = mr;
      mem_write_in    = mw;
      mem_size_in     = sz;
      mem_unsigned_in = u;
      inst_in         = inst;
   endtask

   task automatic bubble();
      drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            2'b00, 1'b0, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      bubble();
      tick();
      tick();
      check("rst_res", final_result, 32'd0);
      check("rst_rwf", 32'(reg_write_final), 32'd0);
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_bad", bad_vaddr, 32'd0);
      check("rst_inst", inst_out, 32'd0);
      rst = 1'b0;

      // ADD
      drive(1'b1, 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
            2'b10, 1'b0, 32'h0000_1020);
      tick();
      bubble();
      #1;
      check("add_noreq", 32'(dmem_req), 32'd0);
      tick();
      check("add_res", final_result, 32'h1234);
      check("add_wr", 32'(write_reg), 32'd5);
      check("add_rwf", 32'(reg_write_final), 32'd1);
      check("add_inst", inst_out, 32'h0000_1020);
      check("add_noreq2", 32'(dmem_req), 32'd0);
      tick();
      check("bub_rwf", 32'(reg_write_final), 32'd0);
      check("bub_res", final_result, 32'h1234);

      // flushed ADD becomes a bubble
      drive(1'b1, 32'h777, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0,
            2'b10, 1'b0, 32'h1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bubble();
      tick();
      check("flush_rwf", 32'(reg_write_final), 32'd0);
      check("flush_res", final_result, 32'h1234);

      // stall holds MEM/WB, then the held op retires
      drive(1'b1, 32'h99, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
            2'b10, 1'b0, 32'h2);
      tick();
      stall = 1'b1;
      bubble();
      tick();
      check("stl_res", final_result, 32'h1234);
      stall = 1'b0;
      tick();
      check("stl_res2", final_result, 32'h99);
      check("stl_wr", 32'(write_reg), 32'd3);

      // LB then LBU back-to-back at 0x103
      dmem_ready = 1'b1;
      dmem_rdata = 32'h80AA_BBCC;
      drive(1'b1, 32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0,
            2'b00, 1'b0, 32'h3);
      tick();
      drive(1'b1, 32'h103, 32'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0,
            2'b00, 1'b1, 32'h4);
      #1;
      check("lb_req", 32'(dmem_req), 32'd1);
      check("lb_addr", dmem_addr, 32'h100);
      check("lb_we", 32'(dmem_we), 32'd0);
      check("lb_wstrb", 32'(dmem_wstrb), 32'd0);
      check("lb_mstall", 32'(mem_stall), 32'd0);
      tick();
      check("lb_res", final_result, 32'hFFFF_FF80);
      check("lb_wr", 32'(write_reg), 32'd7);
      check("lb_m2r", 32'(mem_to_reg_final), 32'd1);
      check("b2b_req", 32'(dmem_req), 32'd1);
      bubble();
      tick();
      check("lbu_res", final_result, 32'h0000_0080);
      check("lbu_wr", 32'(write_reg), 32'd8);
      check("lbu_idle", 32'(dmem_req), 32'd0);

      // LH at 0x102
      drive(1'b1, 32'h102, 32'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0,
            2'b01, 1'b0, 32'h5);
      tick();
      bubble();
      tick();
      check("lh_res", final_result, 32'hFFFF_80AA);

      // SB of 0xA5 at 0x101
      drive(1'b1, 32'h101, 32'h0000_00A5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1,
            2'b00, 1'b0, 32'h6);
      tick();
      bubble();
      #1;
      check("sb_req", 32'(dmem_req), 32'd1);
      check("sb_we", 32'(dmem_we), 32'd1);
      check("sb_addr", dmem_addr, 32'h100);
      check("sb_wstrb", 32'(dmem_wstrb), 32'h2);
      check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      tick();
      check("sb_res", final_result, 32'd0);
      check("sb_rwf", 32'(reg_write_final), 32'd0);

      // SH of 0x1234BEEF at 0x102
      drive(1'b1, 32'h102, 32'h1234_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
            2'b01, 1'b0, 32'h7);
      tick();
      bubble();
      #1;
      check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
      check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      tick();

      // ADD then LW with ready low for 3 cycles
      dmem_ready = 1'b0;
      dmem_rdata = 32'h1234_5678;
      drive(1'b1, 32'h42, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0,
            2'b10, 1'b0, 32'h8);
      tick();
      drive(1'b1, 32'h2000, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0,
            2'b10, 1'b0, 32'h9);
      tick();
      check("pre_res", final_result, 32'h42);
      check("pre_rwf", 32'(reg_write_final), 32'd1);
      bubble();
      stalls = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (mem_stall) stalls++;
         check("lw_addr", dmem_addr, 32'h2000);
         tick();
         check("lw_bub_rwf", 32'(reg_write_final), 32'd0);
      end
      dmem_ready = 1'b1;
      #1;
      if (mem_stall) stalls++;
      check("lw_stalls", 32'(stalls), 32'd3);
      tick();
      check("lw_res", final_result, 32'h1234_5678);
      check("lw_wr", 32'(write_reg), 32'd9);
      check("lw_rwf", 32'(reg_write_final), 32'd1);

      // misaligned LW at 0x2002
      drive(1'b1, 32'h2002, 32'd0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0,
            2'b10, 1'b0, 32'hA);
      tick();
      bubble();
      #1;
      check("mis_req", 32'(dmem_req), 32'd0);
      tick();
      check("mis_err", 32'(addr_err), 32'd1);
      check("mis_bad", bad_vaddr, 32'h2002);
      check("mis_rwf", 32'(reg_write_final), 32'd0);
      tick();
      check("mis_err_clr", 32'(addr_err), 32'd0);
      check("mis_bad_hold", bad_vaddr, 32'h2002);

      // stall together with ready -> HOLD
      dmem_rdata = 32'hCAFE_F00D;
      drive(1'b1, 32'h55, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0,
            2'b10, 1'b0, 32'hB);
      tick();
      drive(1'b1, 32'h3000, 32'd0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0,
            2'b10, 1'b0, 32'hC);
      tick();
      stall = 1'b1;
      bubble();
      #1;
      check("hld_req", 32'(dmem_req), 32'd1);
      check("hld_mstall", 32'(mem_stall), 32'd0);
      tick();
      dmem_rdata = 32'hDEAD_BEEF;
      dmem_ready = 1'b0;
      #1;
      check("hld_noreq", 32'(dmem_req), 32'd0);
      check("hld_res", final_result, 32'h55);
      tick();
      check("hld_res2", final_result, 32'h55);
      stall = 1'b0;
      tick();
      check("hld_out", final_result, 32'hCAFE_F00D);
      check("hld_wr", 32'(write_reg), 32'd13);
      check("hld_rwf", 32'(reg_write_final), 32'd1);
      tick();
      check("hld_post_rwf", 32'(reg_write_final), 32'd0);
      check("hld_post_req", 32'(dmem_req), 32'd0);

      // reset in the middle of a request
      drive(1'b1, 32'h4000, 32'd0, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0,
            2'b10, 1'b0, 32'hD);
      tick();
      bubble();
      #1;
      check("rmid_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      tick();
      check("rmid_req0", 32'(dmem_req), 32'd0);
      check("rmid_res", final_result, 32'd0);
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
